// File: rtl/seletor_varredura.sv
// Digit scan selector for a 4-digit multiplexed display.
// Drives decoder select {B,A} and enable with blanking between digits.
module seletor_varredura #(
  parameter int DIV_MAX   = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       A,
  output logic       B,
  output logic       en,
  output logic       tick,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHOW  = 2'b01,
    BLANK = 2'b10,
    BAD   = 2'b11
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(DIV_MAX - 1);
  localparam logic [7:0]  BLANK_LAST =
    8'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYC > 0);

  state_t      state, state_n;
  logic [1:0]  digit, digit_n;
  logic [15:0] presc, presc_n;
  logic [7:0]  blank, blank_n;
  logic        en_n, tick_n;

  // Next-state, counters and registered-output precompute
  always_comb begin
    state_n = state;
    digit_n = digit;
    presc_n = presc;
    blank_n = blank;
    tick_n  = 1'b0;
    unique case (state)
      IDLE: begin
        presc_n = '0;
        blank_n = '0;
        if (run) state_n = SHOW;
      end
      SHOW: begin
        if (!run) begin
          state_n = IDLE;
          presc_n = '0;
          blank_n = '0;
        end else if (presc == PRESC_LAST) begin
          digit_n = digit + 2'd1;
          tick_n  = 1'b1;
          presc_n = '0;
          blank_n = '0;
          if (HAS_BLANK) state_n = BLANK;
        end else begin
          presc_n = presc + 16'd1;
        end
      end
      BLANK: begin
        if (!run) begin
          state_n = IDLE;
          presc_n = '0;
          blank_n = '0;
        end else if (blank == BLANK_LAST) begin
          state_n = SHOW;
          presc_n = '0;
          blank_n = '0;
        end else begin
          blank_n = blank + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        presc_n = '0;
        blank_n = '0;
      end
    endcase
    en_n = (state_n == SHOW);
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      digit <= 2'd0;
      presc <= '0;
      blank <= '0;
      en    <= 1'b0;
      tick  <= 1'b0;
    end else begin
      state <= state_n;
      digit <= digit_n;
      presc <= presc_n;
      blank <= blank_n;
      en    <= en_n;
      tick  <= tick_n;
    end
  end

  assign A       = digit[0];
  assign B       = digit[1];
  assign state_o = state;

endmodule
